matrix_transpose_seq: RTL and testbench

Sequential, parametrised matrix transpose engine for the matrix-operation datapath. It captures an up-to MAX_DIM × MAX_DIM matrix on a start handshake and moves one element per cycle into a registered output buffer. It supports transpose and copy modes, reports dimension errors, and holds the result with a valid flag until the next job. It replaces the single-cycle combinational transpose where timing closure on the wide mux is the limiter.

---
 rtl/matrix_transpose_seq.sv | 160 ++++++++++++++++
 tb/tb_matrix_transpose_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_transpose_seq.sv
// matrix_transpose_seq: sequential matrix transpose/copy engine.
// Captures up to MAX_DIM x MAX_DIM elements on an accepted start, then moves
// one element per cycle into a registered output buffer. The result is held
// with a valid flag until the next accepted job.
module matrix_transpose_seq #(
    parameter int DW       = 8,
    parameter int MAX_DIM  = 5,
    localparam int DIMW    = $clog2(MAX_DIM + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          mode,
    input  logic [DIMW-1:0]               m_in,
    input  logic [DIMW-1:0]               n_in,
    input  logic [MAX_DIM*MAX_DIM*DW-1:0] matrix_in,
    output logic                          busy,
    output logic                          done,
    output logic                          valid,
    output logic                          error,
    output logic [DIMW-1:0]               m_out,
    output logic [DIMW-1:0]               n_out,
    output logic [MAX_DIM*MAX_DIM*DW-1:0] matrix_out
);

    localparam int NE   = MAX_DIM * MAX_DIM;
    localparam int IDXW = (NE > 1) ? $clog2(NE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [DIMW-1:0]  m_reg, n_reg;
    logic             mode_reg;
    logic [NE*DW-1:0] mat_reg;
    logic [DIMW-1:0]  i_reg, j_reg;
    logic             done_reg, valid_reg, error_reg;
    logic [DIMW-1:0]  m_out_reg, n_out_reg;

    logic             accept;
    logic             dims_bad;
    logic             last_elem;
    logic             clear_out;
    logic             wr_en;
    logic [IDXW-1:0]  src_idx, dst_idx;
    logic [DW-1:0]    rd_data;

    // Job acceptance, dimension legality and element addressing.
    always_comb begin
        accept    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
        dims_bad  = (m_reg == '0) || (n_reg == '0) ||
                    (m_reg > DIMW'(MAX_DIM)) || (n_reg > DIMW'(MAX_DIM));
        last_elem = (i_reg == m_reg - DIMW'(1)) && (j_reg == n_reg - DIMW'(1));
        clear_out = (state_reg == ST_CHECK);
        wr_en     = (state_reg == ST_RUN);
        src_idx   = IDXW'(i_reg) * IDXW'(MAX_DIM) + IDXW'(j_reg);
        dst_idx   = mode_reg ? src_idx
                             : IDXW'(j_reg) * IDXW'(MAX_DIM) + IDXW'(i_reg);
        rd_data   = mat_reg[int'(src_idx) * DW +: DW];
    end

    // Next-state selection for IDLE -> CHECK -> RUN -> DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start)     state_next = ST_CHECK;
            ST_CHECK:         state_next = dims_bad ? ST_DONE : ST_RUN;
            ST_RUN:           if (last_elem) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // State, job capture, counters and result status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            m_reg     <= '0;
            n_reg     <= '0;
            mode_reg  <= 1'b0;
            mat_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
            m_out_reg <= '0;
            n_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            // done is a single-cycle pulse on every entry into DONE
            done_reg  <= (state_next == ST_DONE) && (state_reg != ST_DONE);

            if (accept) begin
                m_reg     <= m_in;
                n_reg     <= n_in;
                mode_reg  <= mode;
                mat_reg   <= matrix_in;
                valid_reg <= 1'b0;
                error_reg <= 1'b0;
            end

            if (state_reg == ST_CHECK) begin
                i_reg <= '0;
                j_reg <= '0;
                if (dims_bad) begin
                    error_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    m_out_reg <= '0;
                    n_out_reg <= '0;
                end
            end

            if (state_reg == ST_RUN) begin
                // column index runs fastest, wrapping into the next row
                if (j_reg == n_reg - DIMW'(1)) begin
                    j_reg <= '0;
                    i_reg <= i_reg + DIMW'(1);
                end else begin
                    j_reg <= j_reg + DIMW'(1);
                end
                if (last_elem) begin
                    valid_reg <= 1'b1;
                    m_out_reg <= mode_reg ? m_reg : n_reg;
                    n_out_reg <= mode_reg ? n_reg : m_reg;
                end
            end
        end
    end

    // One register per output element: cleared in CHECK, loaded when addressed in RUN.
    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : g_elem
            logic [DW-1:0] out_el_reg;

            // Per-element clear/write; only the addressed element changes.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_el_reg <= '0;
                end else if (clear_out) begin
                    out_el_reg <= '0;
                end else if (wr_en && (dst_idx == IDXW'(gi))) begin
                    out_el_reg <= rd_data;
                end
            end

            assign matrix_out[gi*DW +: DW] = out_el_reg;
        end
    endgenerate

    assign busy  = (state_reg == ST_CHECK) || (state_reg == ST_RUN);
    assign done  = done_reg;
    assign valid = valid_reg;
    assign error = error_reg;
    assign m_out = m_out_reg;
    assign n_out = n_out_reg;

endmodule

// File: tb/tb_matrix_transpose_seq.sv
// Directed bench for matrix_transpose_seq: table of jobs plus hand-written
// sequences for ignored starts, held start and asynchronous reset mid-job.
module tb_matrix_transpose_seq;

    localparam int DW   = 8;
    localparam int MAXD = 5;
    localparam int DIMW = 3;
    localparam int W    = MAXD * MAXD * DW;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            mode;
    logic [DIMW-1:0] m_in, n_in, m_out, n_out;
    logic [W-1:0]    matrix_in, matrix_out;
    logic            busy, done, valid, error;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic            mode;
        logic [DIMW-1:0] m;
        logic [DIMW-1:0] n;
        logic [W-1:0]    mat;
        logic            exp_err;
        logic [DIMW-1:0] exp_m;
        logic [DIMW-1:0] exp_n;
        logic [W-1:0]    exp_mat;
        int              exp_lat;
        int              exp_busy;
    } vec_t;

    vec_t vecs[6];

    matrix_transpose_seq #(.DW(DW), .MAX_DIM(MAXD)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .m_in       (m_in),
        .n_in       (n_in),
        .matrix_in  (matrix_in),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .error      (error),
        .m_out      (m_out),
        .n_out      (n_out),
        .matrix_out (matrix_out)
    );

    always #5 clk = ~clk;

    function automatic int off(input int r, input int c);
        return (r * MAXD + c) * DW;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input int idx);
        int got;
        int bcnt;
        got  = -1;
        bcnt = 0;
        @(negedge clk);
        start     = 1'b1;
        mode      = vecs[idx].mode;
        m_in      = vecs[idx].m;
        n_in      = vecs[idx].n;
        matrix_in = vecs[idx].mat;
        @(posedge clk);
        #1;
        start     = 1'b0;
        matrix_in = '1;
        m_in      = '0;
        n_in      = '0;
        mode      = ~mode;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                got = k;
                break;
            end
        end
        chk("latency",    W'(got),        W'(vecs[idx].exp_lat));
        chk("busy_len",   W'(bcnt),       W'(vecs[idx].exp_busy));
        chk("error",      W'(error),      W'(vecs[idx].exp_err));
        chk("valid",      W'(valid),      W'(!vecs[idx].exp_err));
        chk("m_out",      W'(m_out),      W'(vecs[idx].exp_m));
        chk("n_out",      W'(n_out),      W'(vecs[idx].exp_n));
        chk("matrix_out", matrix_out,     vecs[idx].exp_mat);
        $display("job %0d mode=%0d %0dx%0d done@T+%0d busy=%0d m_out=%0d n_out=%0d err=%0d",
                 idx, vecs[idx].mode, vecs[idx].m, vecs[idx].n, got, bcnt, m_out, n_out, error);
        @(negedge clk);
        chk("done_pulse", W'(done),       W'(0));
        chk("valid_hold", W'(valid),      W'(!vecs[idx].exp_err));
        chk("mat_hold",   matrix_out,     vecs[idx].exp_mat);
    endtask

    initial begin
        logic [W-1:0] exp_m;
        int got;

        reset = 1'b1; start = 1'b0; mode = 1'b0;
        m_in = '0; n_in = '0; matrix_in = '0;

        // Job table
        for (int v = 0; v < 6; v++) begin
            vecs[v].mat = '0; vecs[v].exp_mat = '0; vecs[v].mode = 1'b0;
            vecs[v].exp_err = 1'b0;
        end
        // 0: 2x3 transpose
        vecs[0].m = 3'd2; vecs[0].n = 3'd3;
        vecs[0].mat[off(0,0) +: 8] = 8'h01; vecs[0].mat[off(0,1) +: 8] = 8'h02;
        vecs[0].mat[off(0,2) +: 8] = 8'h03; vecs[0].mat[off(1,0) +: 8] = 8'h04;
        vecs[0].mat[off(1,1) +: 8] = 8'h05; vecs[0].mat[off(1,2) +: 8] = 8'h06;
        vecs[0].exp_mat[off(0,0) +: 8] = 8'h01; vecs[0].exp_mat[off(0,1) +: 8] = 8'h04;
        vecs[0].exp_mat[off(1,0) +: 8] = 8'h02; vecs[0].exp_mat[off(1,1) +: 8] = 8'h05;
        vecs[0].exp_mat[off(2,0) +: 8] = 8'h03; vecs[0].exp_mat[off(2,1) +: 8] = 8'h06;
        vecs[0].exp_m = 3'd3; vecs[0].exp_n = 3'd2; vecs[0].exp_lat = 8; vecs[0].exp_busy = 7;
        // 1: 5x5 transpose, element = r*16+c
        vecs[1].m = 3'd5; vecs[1].n = 3'd5;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                vecs[1].mat[off(r,c) +: 8]     = 8'(r * 16 + c);
                vecs[1].exp_mat[off(c,r) +: 8] = 8'(r * 16 + c);
            end
        vecs[1].exp_m = 3'd5; vecs[1].exp_n = 3'd5; vecs[1].exp_lat = 27; vecs[1].exp_busy = 26;
        // 2: illegal 0x3
        vecs[2].m = 3'd0; vecs[2].n = 3'd3; vecs[2].mat = {25{8'h3C}};
        vecs[2].exp_err = 1'b1; vecs[2].exp_m = 3'd0; vecs[2].exp_n = 3'd0;
        vecs[2].exp_lat = 2; vecs[2].exp_busy = 1;
        // 3: illegal 6x2
        vecs[3].m = 3'd6; vecs[3].n = 3'd2; vecs[3].mat = {25{8'hC3}};
        vecs[3].exp_err = 1'b1; vecs[3].exp_m = 3'd0; vecs[3].exp_n = 3'd0;
        vecs[3].exp_lat = 2; vecs[3].exp_busy = 1;
        // 4: copy 3x1
        vecs[4].mode = 1'b1; vecs[4].m = 3'd3; vecs[4].n = 3'd1;
        vecs[4].mat[off(0,0) +: 8] = 8'h0A; vecs[4].mat[off(1,0) +: 8] = 8'h0B;
        vecs[4].mat[off(2,0) +: 8] = 8'h0C;
        vecs[4].exp_mat = vecs[4].mat;
        vecs[4].exp_m = 3'd3; vecs[4].exp_n = 3'd1; vecs[4].exp_lat = 5; vecs[4].exp_busy = 4;
        // 5: 1x1 transpose
        vecs[5].m = 3'd1; vecs[5].n = 3'd1;
        vecs[5].mat[off(0,0) +: 8] = 8'h5A; vecs[5].exp_mat = vecs[5].mat;
        vecs[5].exp_m = 3'd1; vecs[5].exp_n = 3'd1; vecs[5].exp_lat = 3; vecs[5].exp_busy = 2;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy",  W'(busy),  W'(0));
        chk("rst_done",  W'(done),  W'(0));
        chk("rst_valid", W'(valid), W'(0));
        chk("rst_error", W'(error), W'(0));
        chk("rst_m_out", W'(m_out), W'(0));
        chk("rst_n_out", W'(n_out), W'(0));
        chk("rst_mat",   matrix_out, '0);
        reset = 1'b0;
        $display("reset released, outputs idle");

        for (int v = 0; v < 5; v++) run_job(v);

        // start held high across a 1x1 job: restart right after DONE
        @(negedge clk);
        start = 1'b1; mode = 1'b0; m_in = 3'd1; n_in = 3'd1;
        matrix_in = '0; matrix_in[off(0,0) +: 8] = 8'h77;
        exp_m = matrix_in;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) chk("held_done1", W'(done), W'(1));
            if (k == 4) begin
                chk("held_done_low", W'(done),  W'(0));
                chk("held_valid_drop", W'(valid), W'(0));
                chk("held_busy", W'(busy), W'(1));
            end
            if (k == 6) begin
                chk("held_done2", W'(done), W'(1));
                chk("held_valid", W'(valid), W'(1));
                chk("held_mat", matrix_out, exp_m);
                start = 1'b0;
            end
        end
        $display("held-start 1x1 restarted, second done at T+6");

        // 2x2 transpose with starts in cycles T+1 and T+4 ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b0; m_in = 3'd2; n_in = 3'd2; matrix_in = '0;
        matrix_in[off(0,0) +: 8] = 8'h11; matrix_in[off(0,1) +: 8] = 8'h12;
        matrix_in[off(1,0) +: 8] = 8'h13; matrix_in[off(1,1) +: 8] = 8'h14;
        exp_m = '0;
        exp_m[off(0,0) +: 8] = 8'h11; exp_m[off(0,1) +: 8] = 8'h13;
        exp_m[off(1,0) +: 8] = 8'h12; exp_m[off(1,1) +: 8] = 8'h14;
        @(posedge clk);
        #1;
        start = 1'b0; matrix_in = {25{8'hEE}}; m_in = 3'd1; n_in = 3'd1;
        got = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                got = k;
                break;
            end
            start = (k == 1) || (k == 4);
        end
        start = 1'b0;
        chk("ign_latency", W'(got),   W'(6));
        chk("ign_m_out",   W'(m_out), W'(2));
        chk("ign_n_out",   W'(n_out), W'(2));
        chk("ign_mat",     matrix_out, exp_m);
        $display("2x2 with ignored starts: done@T+%0d m_out=%0d n_out=%0d", got, m_out, n_out);
        // start while in DONE is accepted
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_accept_valid", W'(valid), W'(0));
        chk("done_accept_busy",  W'(busy),  W'(1));
        got = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                got = k;
                break;
            end
        end
        chk("done_accept_fin", W'(got > 0), W'(1));
        $display("start in DONE accepted, job finished");

        // Asynchronous reset in the middle of a 4x4 copy
        @(negedge clk);
        start = 1'b1; mode = 1'b1; m_in = 3'd4; n_in = 3'd4; matrix_in = {25{8'hA5}};
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", W'(busy), W'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy",  W'(busy),  W'(0));
        chk("arst_done",  W'(done),  W'(0));
        chk("arst_valid", W'(valid), W'(0));
        chk("arst_error", W'(error), W'(0));
        chk("arst_m_out", W'(m_out), W'(0));
        chk("arst_n_out", W'(n_out), W'(0));
        chk("arst_mat",   matrix_out, '0);
        @(negedge clk);
        chk("arst_no_done", W'(done), W'(0));
        reset = 1'b0;
        $display("async reset mid-RUN cleared all outputs");
        run_job(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
